// File: rtl/dest_sched.sv
// Per-partition ingress scheduler: filters local packets into one-entry slots per input and
// drains them round-robin onto a single registered valid/ready output.
module dest_sched #(
  parameter int unsigned N   = 8,
  parameter int unsigned SW  = 3,
  parameter int unsigned AW  = 11,
  parameter int unsigned DW  = 32,
  parameter logic [3:0]  PID = 4'h0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]    in_valid,
  input  logic [N*AW-1:0] in_nexthop,
  input  logic [N*DW-1:0] in_data,
  output logic [N-1:0]    in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_nexthop,
  output logic [DW-1:0] out_data,
  output logic [SW-1:0] out_src,
  output logic [7:0]    drop_count
);

  logic [N-1:0]  r_full;
  logic [AW-1:0] r_nh   [N];
  logic [DW-1:0] r_data [N];
  logic [SW-1:0] r_rr;
  logic          r_out_valid;
  logic [AW-1:0] r_out_nh;
  logic [DW-1:0] r_out_data;
  logic [SW-1:0] r_out_src;
  logic [7:0]    r_drop;

  logic          w_out_free;
  logic          w_gnt_found;
  logic [SW-1:0] w_gnt_idx;
  logic [N-1:0]  w_grant;
  logic [N-1:0]  w_local;
  logic [N-1:0]  w_xfer;
  logic [8:0]    w_drop_n;
  logic [8:0]    w_drop_sum;
  logic [7:0]    w_drop_next;

  assign w_out_free = ~r_out_valid | out_ready;

  // First full slot at or after the round-robin pointer, wrapping mod N.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!w_gnt_found && r_full[(32'(r_rr) + k) % N]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = SW'((32'(r_rr) + k) % N);
      end
    end
  end

  assign w_grant  = (w_gnt_found && w_out_free) ? (N'(1) << w_gnt_idx) : '0;
  // Depends only on registered state and out_ready, never on in_valid/in_nexthop.
  assign in_ready = ~r_full | w_grant;
  assign w_xfer   = in_valid & in_ready;

  always_comb begin
    w_local  = '0;
    w_drop_n = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_local[i] = (in_nexthop[i*AW+AW-1 -: 4] == PID);
      w_drop_n   = w_drop_n + 9'(w_xfer[i] & ~w_local[i]);
    end
    w_drop_sum  = {1'b0, r_drop} + w_drop_n;
    w_drop_next = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
  end

  // A refill in the same cycle as a grant wins, so full stays set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_full <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        r_nh[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (w_xfer[i] && w_local[i]) begin
          r_full[i] <= 1'b1;
          r_nh[i]   <= in_nexthop[i*AW +: AW];
          r_data[i] <= in_data[i*DW +: DW];
        end else if (w_grant[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_nh    <= '0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_rr        <= '0;
      r_drop      <= '0;
    end else begin
      r_drop <= w_drop_next;
      if (w_out_free) begin
        if (w_gnt_found) begin
          r_out_valid <= 1'b1;
          r_out_nh    <= r_nh[w_gnt_idx];
          r_out_data  <= r_data[w_gnt_idx];
          r_out_src   <= w_gnt_idx;
          r_rr        <= SW'((32'(w_gnt_idx) + 1) % N);
        end else begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_nexthop = r_out_nh;
  assign out_data    = r_out_data;
  assign out_src     = r_out_src;
  assign drop_count  = r_drop;

endmodule

// File: tb/tb_dest_sched.sv
// Directed bench for dest_sched: queue-level reference model compared every cycle, plus
// hand-computed literal checks for each scenario.
module tb_dest_sched;
  localparam int N = 8, SW = 3, AW = 11, DW = 32;
  localparam logic [3:0] PID = 4'h0;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]    in_valid = '0;
  logic [N*AW-1:0] in_nexthop = '0;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_nexthop;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_src;
  logic [7:0]    drop_count;

  dest_sched #(.N(N), .SW(SW), .AW(AW), .DW(DW), .PID(PID)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_nexthop(in_nexthop),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_nexthop(out_nexthop), .out_data(out_data), .out_src(out_src), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] seq = 8'd0;

  // Reference model: one optional packet per input, one optional output packet.
  bit            m_full [N];
  logic [AW-1:0] m_nh   [N];
  logic [DW-1:0] m_data [N];
  int            m_rr, m_src, m_drop;
  bit            m_ov;
  logic [AW-1:0] m_onh;
  logic [DW-1:0] m_odata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_full[i] = 0;
    m_rr = 0; m_ov = 0; m_src = 0; m_drop = 0;
  endtask

  function automatic bit m_free();
    return !m_ov || out_ready;
  endfunction

  function automatic int m_pick();
    if (!m_free()) return -1;
    for (int k = 0; k < N; k++)
      if (m_full[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int g = m_pick();
    for (int i = 0; i < N; i++) r[i] = !m_full[i] || (i == g);
    return r;
  endfunction

  task automatic model_step();
    logic [N-1:0] rdy = m_ready();
    int g = m_pick();
    int drops = 0;
    if (m_free()) begin
      if (g >= 0) begin
        m_ov = 1; m_onh = m_nh[g]; m_odata = m_data[g]; m_src = g;
        m_full[g] = 0; m_rr = (g + 1) % N;
      end else m_ov = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && rdy[i]) begin
        if (in_nexthop[i*AW+AW-1 -: 4] == PID) begin
          m_full[i] = 1; m_nh[i] = in_nexthop[i*AW +: AW]; m_data[i] = in_data[i*DW +: DW];
        end else drops++;
      end
    end
    m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      chk("drop_count", 64'(drop_count), 64'(m_drop));
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("in_ready", 64'(in_ready), 64'(m_ready()));
      if (m_ov) begin
        chk("out_src", 64'(out_src), 64'(m_src));
        chk("out_nexthop", 64'(out_nexthop), 64'(m_onh));
        chk("out_data", 64'(out_data), 64'(m_odata));
      end
    end
  end

  // One cycle: drive inputs, advance model at the edge, return just after the next falling edge.
  task automatic tick(input logic [N-1:0] mask, input logic [3:0] pid, input logic ordy);
    in_valid = mask;
    out_ready = ordy;
    for (int i = 0; i < N; i++) begin
      in_nexthop[i*AW +: AW] = {pid, 4'h5, 3'(i + 7)};
      in_data[i*DW +: DW] = 32'hA5A5_0000 | (32'(seq) << 8) | 32'(i);
    end
    if (mask != '0) seq++;
    @(posedge clock);
    model_step();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    in_valid = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    model_clear();
    do_reset();

    // Idle after reset.
    for (int c = 0; c < 4; c++) tick('0, PID, 1'b1);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'hFF);
    chk("idle_drop", 64'(drop_count), 64'd0);

    // Single packet on input 3, two-cycle latency.
    tick(8'h08, PID, 1'b1);
    chk("lat1_out_valid", 64'(out_valid), 64'd0);
    tick('0, PID, 1'b1);
    chk("lat2_out_valid", 64'(out_valid), 64'd1);
    chk("lat2_out_src", 64'(out_src), 64'd3);
    chk("lat2_out_nexthop", 64'(out_nexthop), 64'({PID, 4'h5, 3'h2}));
    chk("lat2_out_data", 64'(out_data), 64'h0000_0000_A5A5_0003);
    tick('0, PID, 1'b1);

    // All eight inputs at once drain in index order.
    do_reset();
    tick(8'hFF, PID, 1'b1);
    for (int k = 0; k < N; k++) begin
      tick('0, PID, 1'b1);
      chk("rr_valid", 64'(out_valid), 64'd1);
      chk("rr_src", 64'(out_src), 64'(k));
    end
    tick('0, PID, 1'b1);
    chk("rr_empty", 64'(out_valid), 64'd0);

    // Stall with slots 2 and 5 full.
    tick(8'h01, PID, 1'b0);
    tick('0, PID, 1'b0);
    tick(8'h24, PID, 1'b0);
    chk("stall_src", 64'(out_src), 64'd0);
    chk("stall_rdy2", 64'(in_ready[2]), 64'd0);
    chk("stall_rdy5", 64'(in_ready[5]), 64'd0);
    tick('0, PID, 1'b0);
    chk("stall_hold_src", 64'(out_src), 64'd0);
    tick('0, PID, 1'b1);
    chk("rel_src2", 64'(out_src), 64'd2);
    chk("rel_rdy2", 64'(in_ready[2]), 64'd1);
    tick('0, PID, 1'b1);
    chk("rel_src5", 64'(out_src), 64'd5);
    chk("rel_rdy", 64'(in_ready), 64'hFF);
    tick('0, PID, 1'b1);
    chk("rel_empty", 64'(out_valid), 64'd0);

    // Non-local traffic on inputs 1 and 6 is dropped; counter saturates.
    tick(8'h42, PID + 4'h1, 1'b1);
    chk("drop_first", 64'(drop_count), 64'd2);
    for (int c = 1; c < 300; c++) tick(8'h42, PID + 4'h1, 1'b1);
    chk("drop_sat", 64'(drop_count), 64'hFF);
    chk("drop_no_out", 64'(out_valid), 64'd0);

    // Asynchronous reset with slots 0-4 full and output held.
    do_reset();
    tick(8'h1F, PID, 1'b0);
    tick('0, PID, 1'b0);
    tick(8'h01, PID, 1'b0);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_rdy", 64'(in_ready), 64'hE0);
    in_valid = '0;
    #1 reset = 1'b1;
    model_clear();
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'hFF);
    @(negedge clock);
    reset = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) tick('0, PID, 1'b1);
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
